// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Shared widths and constants for the sound level meter datapath, plus the
// saturating magnitude helper used by the second pipeline stage.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sound_pkg;

    localparam int SAMPLE_W   = 10;   // ADC code width
    localparam int LEVEL_W    = 9;    // rectified level / peak width
    localparam int LED_N      = 8;    // thermometer bar segments
    localparam int BIAS_W     = 16;   // bias tracker, 10.6 fixed point
    localparam int DIFF_W     = 11;   // signed sample - bias

    localparam int BIAS_RESET = 512;  // mid-scale start point for the bias
    localparam int CLIP_LO    = 8;
    localparam int CLIP_HI    = 1015;
    localparam int CLIP_HOLD  = 255;

    // |d| clamped to the largest value a LEVEL_W word can carry.
    function automatic logic [LEVEL_W-1:0] sat_mag(input logic [DIFF_W-1:0] d);
        logic [DIFF_W-1:0] a;
        a = d[DIFF_W-1] ? (~d + DIFF_W'(1)) : d;
        return (a > DIFF_W'((1 << LEVEL_W) - 1)) ? LEVEL_W'((1 << LEVEL_W) - 1)
                                                 : a[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/peak_hold_decay.sv
// -----------------------------------------------------------------------------
// peak_hold_decay
// Final pipeline stage: peak register with hold timer and linear decay, and
// the thermometer compare that drives the LED bar. Everything advances only
// when upd is high, so the display holds still while no samples arrive.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   upd          a new magnitude is presented on mag this cycle
//   mag          rectified deviation of the current sample
//   level        held peak (registered)
//   led          thermometer bar, led[0] lowest (registered)
//   level_valid  one-cycle pulse when level/led were just updated
// -----------------------------------------------------------------------------
module peak_hold_decay
    import sound_pkg::*;
#(
    parameter int HOLD_SAMPLES = 4,
    parameter int DECAY_STEP   = 8,
    parameter int THRESH_STEP  = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd,
    input  logic [LEVEL_W-1:0] mag,
    output logic [LEVEL_W-1:0] level,
    output logic [LED_N-1:0]   led,
    output logic               level_valid
);

    localparam int HOLD_W = 8;

    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [LED_N-1:0]   led_q, led_d;
    logic               valid_q, valid_d;

    always_comb begin
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        valid_d    = upd;
        if (upd) begin
            // A magnitude equal to the peak is not a new peak: the hold
            // timer keeps running.
            if (mag > peak_q) begin
                peak_d     = mag;
                hold_cnt_d = HOLD_W'(HOLD_SAMPLES);
            end else if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end else if (peak_q > LEVEL_W'(DECAY_STEP)) begin
                peak_d = peak_q - LEVEL_W'(DECAY_STEP);
            end else begin
                peak_d = '0;
            end
        end
        // Bar follows the next peak so both outputs change on the same edge.
        led_d = '0;
        for (int i = 0; i < LED_N; i++) begin
            led_d[i] = (12'(peak_d) >= 12'((i + 1) * THRESH_STEP));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q     <= '0;
            hold_cnt_q <= '0;
            led_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            peak_q     <= peak_d;
            hold_cnt_q <= hold_cnt_d;
            led_q      <= led_d;
            valid_q    <= valid_d;
        end
    end

    assign level       = peak_q;
    assign led         = led_q;
    assign level_valid = valid_q;

endmodule

// File: rtl/sound_level_meter.sv
// -----------------------------------------------------------------------------
// sound_level_meter
// Three-stage meter on the ADC sample stream:
//   S1  capture, signed deviation from the tracked DC bias, IIR bias update
//   S2  saturating magnitude
//   S3  peak hold / decay and LED bar (peak_hold_decay)
// An accepted strobe in cycle N produces a level_valid pulse in cycle N+3.
// Optional build macro: SOUND_LEVEL_METER_CLIP_DETECT_EN enables the clip
// indicator; without it clip is tied low.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   new_sample      sample strobe
//   sample          unsigned 10-bit ADC code
//   sample_channel  channel tag; only CHANNEL is accepted
//   level           held peak magnitude
//   led             thermometer bar, led[0] lowest
//   level_valid     one-cycle pulse when level/led update
//   clip            clip indicator, aligned with level_valid
// -----------------------------------------------------------------------------
module sound_level_meter
    import sound_pkg::*;
#(
    parameter int CHANNEL      = 0,
    parameter int BIAS_SHIFT   = 6,
    parameter int HOLD_SAMPLES = 4,
    parameter int DECAY_STEP   = 8,
    parameter int THRESH_STEP  = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                new_sample,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [3:0]          sample_channel,
    output logic [LEVEL_W-1:0]  level,
    output logic [LED_N-1:0]    led,
    output logic                level_valid,
    output logic                clip
);

    logic                accept;
    logic [BIAS_W-1:0]   sample_scaled;
    logic [SAMPLE_W-1:0] bias_int;

    logic [BIAS_W-1:0]   bias_q, bias_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DIFF_W-1:0]   s1_diff_q, s1_diff_d;
    logic                s2_valid_q, s2_valid_d;
    logic [LEVEL_W-1:0]  s2_mag_q, s2_mag_d;

    always_comb begin
        accept        = new_sample && (sample_channel == 4'(CHANNEL));
        sample_scaled = BIAS_W'(sample) << BIAS_SHIFT;
        bias_int      = SAMPLE_W'(bias_q >> BIAS_SHIFT);

        bias_d     = bias_q;
        s1_valid_d = accept;
        s1_diff_d  = s1_diff_q;
        if (accept) begin
            // Deviation uses the bias as it stood before this sample.
            s1_diff_d = {1'b0, sample} - {1'b0, bias_int};
            // 17-bit signed step toward the sample; the sum always lands
            // between the old bias and the sample, so 16 bits hold it.
            bias_d = bias_q + BIAS_W'($signed({1'b0, sample_scaled} - {1'b0, bias_q})
                                      >>> BIAS_SHIFT);
        end

        s2_valid_d = s1_valid_q;
        s2_mag_d   = s1_valid_q ? sat_mag(s1_diff_q) : s2_mag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q     <= BIAS_W'(BIAS_RESET << BIAS_SHIFT);
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
        end else begin
            bias_q     <= bias_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s2_valid_q <= s2_valid_d;
            s2_mag_q   <= s2_mag_d;
        end
    end

    peak_hold_decay #(
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .DECAY_STEP   (DECAY_STEP),
        .THRESH_STEP  (THRESH_STEP)
    ) u_peak (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd         (s2_valid_q),
        .mag         (s2_mag_q),
        .level       (level),
        .led         (led),
        .level_valid (level_valid)
    );

`ifdef SOUND_LEVEL_METER_CLIP_DETECT_EN
    // Clip counter runs in S1; its "non-zero" flag then rides the pipeline
    // so clip changes on the same edge as the matching level update.
    logic [7:0] clip_cnt_q, clip_cnt_d;
    logic       s1_clip_q, s1_clip_d;
    logic       s2_clip_q, s2_clip_d;
    logic       clip_q, clip_d;

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        s1_clip_d  = s1_clip_q;
        if (accept) begin
            if ((sample <= SAMPLE_W'(CLIP_LO)) || (sample >= SAMPLE_W'(CLIP_HI))) begin
                clip_cnt_d = 8'(CLIP_HOLD);
            end else if (clip_cnt_q != '0) begin
                clip_cnt_d = clip_cnt_q - 8'd1;
            end
            s1_clip_d = (clip_cnt_d != '0);
        end
        s2_clip_d = s1_valid_q ? s1_clip_q : s2_clip_q;
        clip_d    = s2_valid_q ? s2_clip_q : clip_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
            s1_clip_q  <= 1'b0;
            s2_clip_q  <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
            s1_clip_q  <= s1_clip_d;
            s2_clip_q  <= s2_clip_d;
            clip_q     <= clip_d;
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

endmodule
